// File: rtl/mem_bus_responder.sv
// Memory-side responder: arbitrates instruction/data requests onto one word array,
// inserts programmable wait states, and returns registered read data plus ready pulses.
module mem_bus_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_addr_bus,
  input  logic              I_MEM_OE,
  input  logic              I_MEM_W,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic [ADDR_W-1:0] d_addr_bus,
  input  logic              D_MEM_OE,
  input  logic              D_MEM_W,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_drive,
  output logic              d_ready,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              last_was_data;
  logic              lat_data;
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  logic d_req_c;
  logic i_req_c;
  logic any_req_c;
  logic grant_data_c;

  // Data port wins unless it won last time and the instruction port is also waiting
  assign d_req_c      = D_MEM_OE | D_MEM_W;
  assign i_req_c      = I_MEM_OE | I_MEM_W;
  assign any_req_c    = d_req_c | i_req_c;
  assign grant_data_c = d_req_c & ~(i_req_c & last_was_data);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (any_req_c) begin
          next_state = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == '0) begin
          next_state = ST_ACCESS;
        end
      end
      ST_ACCESS: next_state = ST_DONE;
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Grant latching, wait counter, read-data capture and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt      <= '0;
      last_was_data <= 1'b0;
      lat_data      <= 1'b0;
      lat_write     <= 1'b0;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      i_rdata       <= '0;
      d_rdata       <= '0;
      i_ready       <= 1'b0;
      d_ready       <= 1'b0;
      d_drive       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      i_ready <= (state == ST_ACCESS) && !lat_data;
      d_ready <= (state == ST_ACCESS) && lat_data;
      d_drive <= (state == ST_ACCESS) && lat_data && !lat_write;
      busy    <= (next_state != ST_IDLE);

      if ((state == ST_IDLE) && any_req_c) begin
        lat_data      <= grant_data_c;
        lat_write     <= grant_data_c ? D_MEM_W    : I_MEM_W;
        lat_addr      <= grant_data_c ? d_addr_bus : i_addr_bus;
        lat_wdata     <= grant_data_c ? d_wdata    : i_wdata;
        last_was_data <= grant_data_c;
        wait_cnt      <= WAIT_LOAD;
      end else if ((state == ST_WAIT) && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - CNT_W'(1);
      end

      if ((state == ST_ACCESS) && !lat_write) begin
        if (lat_data) begin
          d_rdata <= mem[lat_addr];
        end else begin
          i_rdata <= mem[lat_addr];
        end
      end
    end
  end

  // Array write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (!reset && (state == ST_ACCESS) && lat_write) begin
      mem[lat_addr] <= lat_wdata;
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: one instance with one wait state,
// one with zero wait states.
module tb_mem_bus_responder;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic [AW-1:0] a_i_addr, a_d_addr;
  logic          a_i_oe, a_i_w, a_d_oe, a_d_w;
  logic [DW-1:0] a_i_wdata, a_d_wdata, a_i_rdata, a_d_rdata;
  logic          a_i_ready, a_d_ready, a_d_drive, a_busy;

  logic [AW-1:0] b_i_addr, b_d_addr;
  logic          b_i_oe, b_i_w, b_d_oe, b_d_w;
  logic [DW-1:0] b_i_wdata, b_d_wdata, b_i_rdata, b_d_rdata;
  logic          b_i_ready, b_d_ready, b_d_drive, b_busy;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_a_d, exp_a_i, exp_b_i, exp_b_d;

  mem_bus_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(1)) u_dut_a (
    .clk(clk), .reset(reset),
    .i_addr_bus(a_i_addr), .I_MEM_OE(a_i_oe), .I_MEM_W(a_i_w), .i_wdata(a_i_wdata),
    .i_rdata(a_i_rdata), .i_ready(a_i_ready),
    .d_addr_bus(a_d_addr), .D_MEM_OE(a_d_oe), .D_MEM_W(a_d_w), .d_wdata(a_d_wdata),
    .d_rdata(a_d_rdata), .d_drive(a_d_drive), .d_ready(a_d_ready), .busy(a_busy)
  );

  mem_bus_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(0)) u_dut_b (
    .clk(clk), .reset(reset),
    .i_addr_bus(b_i_addr), .I_MEM_OE(b_i_oe), .I_MEM_W(b_i_w), .i_wdata(b_i_wdata),
    .i_rdata(b_i_rdata), .i_ready(b_i_ready),
    .d_addr_bus(b_d_addr), .D_MEM_OE(b_d_oe), .D_MEM_W(b_d_w), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_drive(b_d_drive), .d_ready(b_d_ready), .busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete access on instance A (grant, WAIT, ACCESS, DONE, back to IDLE)
  task automatic a_access(input bit dport, input bit wr, input bit oe,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [DW-1:0] exp_rd, input string tag);
    if (dport) begin
      a_d_addr = addr; a_d_wdata = wd; a_d_w = wr; a_d_oe = oe;
    end else begin
      a_i_addr = addr; a_i_wdata = wd; a_i_w = wr; a_i_oe = oe;
    end
    if (oe && !wr) begin
      if (dport) exp_a_d = exp_rd;
      else       exp_a_i = exp_rd;
    end
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk({tag, "_busy"},   32'(a_busy), 32'(1));
      chk({tag, "_dready"}, 32'(a_d_ready), 32'(dport && c == 3));
      chk({tag, "_iready"}, 32'(a_i_ready), 32'(!dport && c == 3));
      chk({tag, "_drive"},  32'(a_d_drive), 32'(dport && oe && !wr && c == 3));
    end
    chk({tag, "_drdata"}, 32'(a_d_rdata), 32'(exp_a_d));
    chk({tag, "_irdata"}, 32'(a_i_rdata), 32'(exp_a_i));
    a_d_oe = 1'b0; a_d_w = 1'b0; a_i_oe = 1'b0; a_i_w = 1'b0;
    tick();
    chk({tag, "_idle_busy"}, 32'(a_busy), 32'(0));
  endtask

  // One complete instruction-port access on instance B (no wait states)
  task automatic b_access(input bit wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd,
                          input string tag);
    b_i_addr = addr; b_i_wdata = wd; b_i_w = wr; b_i_oe = !wr;
    if (!wr) exp_b_i = exp_rd;
    for (int c = 1; c <= 2; c++) begin
      tick();
      chk({tag, "_busy"},   32'(b_busy), 32'(1));
      chk({tag, "_iready"}, 32'(b_i_ready), 32'(c == 2));
      chk({tag, "_dready"}, 32'(b_d_ready), 32'(0));
    end
    chk({tag, "_irdata"}, 32'(b_i_rdata), 32'(exp_b_i));
    b_i_oe = 1'b0; b_i_w = 1'b0;
    tick();
    chk({tag, "_idle_busy"}, 32'(b_busy), 32'(0));
    chk({tag, "_idle_iready"}, 32'(b_i_ready), 32'(0));
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, "_irdata"}, 32'(a_i_rdata), 32'(0));
    chk({tag, "_drdata"}, 32'(a_d_rdata), 32'(0));
    chk({tag, "_iready"}, 32'(a_i_ready), 32'(0));
    chk({tag, "_dready"}, 32'(a_d_ready), 32'(0));
    chk({tag, "_drive"},  32'(a_d_drive), 32'(0));
    chk({tag, "_busy"},   32'(a_busy), 32'(0));
  endtask

  initial begin
    reset = 1'b1;
    a_i_addr = '0; a_d_addr = '0; a_i_oe = 0; a_i_w = 0; a_d_oe = 0; a_d_w = 0;
    a_i_wdata = '0; a_d_wdata = '0;
    b_i_addr = '0; b_d_addr = '0; b_i_oe = 0; b_i_w = 0; b_d_oe = 0; b_d_w = 0;
    b_i_wdata = '0; b_d_wdata = '0;
    exp_a_d = '0; exp_a_i = '0; exp_b_i = '0; exp_b_d = '0;

    tick();
    tick();
    chk_a_zero("rst_a");
    chk("rst_b_busy", 32'(b_busy), 32'(0));
    chk("rst_b_irdata", 32'(b_i_rdata), 32'(0));
    reset = 1'b0;
    tick();

    // Write then read
    a_access(1, 1, 0, 8'h10, 16'hBEEF, 16'h0000, "wr10");
    a_access(1, 0, 1, 8'h10, 16'h0000, 16'hBEEF, "rd10");

    // Arbitration: preload via D then I so the starvation flag is clear
    a_access(1, 1, 0, 8'h20, 16'h2222, 16'h0000, "pre20");
    a_access(0, 1, 0, 8'h00, 16'h1111, 16'h0000, "pre00");
    a_i_addr = 8'h00; a_i_oe = 1'b1;
    a_d_addr = 8'h20; a_d_oe = 1'b1;
    tick(); tick(); tick();
    chk("arb1_dready", 32'(a_d_ready), 32'(1));
    chk("arb1_iready", 32'(a_i_ready), 32'(0));
    chk("arb1_drdata", 32'(a_d_rdata), 32'(16'h2222));
    chk("arb1_drive",  32'(a_d_drive), 32'(1));
    // D request stays high: it is a fresh request and must lose to the waiting I
    tick();
    chk("arb_idle_busy", 32'(a_busy), 32'(0));
    tick(); tick(); tick();
    chk("arb2_iready", 32'(a_i_ready), 32'(1));
    chk("arb2_dready", 32'(a_d_ready), 32'(0));
    chk("arb2_irdata", 32'(a_i_rdata), 32'(16'h1111));
    chk("arb2_drive",  32'(a_d_drive), 32'(0));
    a_i_oe = 1'b0;
    tick(); tick(); tick(); tick();
    chk("arb3_dready", 32'(a_d_ready), 32'(1));
    chk("arb3_drdata", 32'(a_d_rdata), 32'(16'h2222));
    a_d_oe = 1'b0;
    tick();
    exp_a_d = 16'h2222; exp_a_i = 16'h1111;

    // W and OE together: write wins, no drive, rdata unchanged
    a_access(1, 1, 1, 8'h40, 16'hA5A5, 16'h0000, "wo40");
    a_access(1, 0, 1, 8'h40, 16'h0000, 16'hA5A5, "rd40");

    // Reset during WAIT of a write
    a_access(1, 1, 0, 8'h30, 16'h1234, 16'h0000, "pre30");
    a_d_addr = 8'h30; a_d_wdata = 16'hFFFF; a_d_w = 1'b1;
    tick();
    chk("rstw_busy", 32'(a_busy), 32'(1));
    reset = 1'b1; a_d_w = 1'b0;
    tick();
    chk_a_zero("rstw");
    reset = 1'b0;
    exp_a_d = '0; exp_a_i = '0; exp_b_i = '0;
    tick();
    a_access(1, 0, 1, 8'h30, 16'h0000, 16'h1234, "rd30");

    // Address boundaries
    a_access(1, 1, 0, 8'hFF, 16'h0F0F, 16'h0000, "wrFF");
    a_access(1, 1, 0, 8'h00, 16'hF0F0, 16'h0000, "wr00");
    a_access(1, 0, 1, 8'hFF, 16'h0000, 16'h0F0F, "rdFF");
    a_access(1, 0, 1, 8'h00, 16'h0000, 16'hF0F0, "rd00");

    // Zero wait states: back-to-back fetches
    b_access(1, 8'h01, 16'hC001, 16'h0000, "bw1");
    b_access(1, 8'h02, 16'hC002, 16'h0000, "bw2");
    b_access(1, 8'h03, 16'hC003, 16'h0000, "bw3");
    b_access(1, 8'h04, 16'hC004, 16'h0000, "bw4");
    b_access(0, 8'h01, 16'h0000, 16'hC001, "bf1");
    b_access(0, 8'h02, 16'h0000, 16'hC002, "bf2");
    b_access(0, 8'h03, 16'h0000, 16'hC003, "bf3");
    b_access(0, 8'h04, 16'h0000, 16'hC004, "bf4");
    chk("b_drive", 32'(b_d_drive), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Memory-side responder for the CPU's instruction and data memory strobes. It accepts fetch, read and write requests on two request ports (instruction and data), arbitrates them onto one 256×16 word array, and inserts a programmable number of wait states. It returns read data and a one-cycle ready pulse, and drives the data-bus tristate enable. The CPU top instantiates it directly opposite its `I_MEM_*`/`D_MEM_*` outputs.

## Interface
- `ADDR_W`, 8, address width; array depth is 2^ADDR_W words.
- `DATA_W`, 16, word width.
- `WAIT_STATES`, 1, extra cycles between grant and array access; legal range is 0..7.

- `clk` in 1 — single clock; all state changes on its rising edge.
- `reset` in 1 — synchronous, active-high.
- `i_addr_bus` in ADDR_W — instruction-port address.
- `I_MEM_OE` in 1 — instruction fetch request (level).
- `I_MEM_W` in 1 — instruction-port write request (program load, level).
- `i_wdata` in DATA_W — instruction-port write data.
- `i_rdata` out DATA_W — fetched word.
- `i_ready` out 1 — one-cycle completion pulse, instruction port.
- `d_addr_bus` in ADDR_W — data-port address.
- `D_MEM_OE` in 1 — data read request (level).
- `D_MEM_W` in 1 — data write request (level).
- `d_wdata` in DATA_W — data-port write data.
- `d_rdata` out DATA_W — read word, routed to DATA_BUS via the top-level tristate.
- `d_drive` out 1 — tristate enable for DATA_BUS.
- `d_ready` out 1 — one-cycle completion pulse, data port.
- `busy` out 1 — high in every state except IDLE.

## Operation
- **Requests**
  - A port requests when its OE or W is high. Requests are level-held by the master until that port's ready pulse.
  - If W and OE are both high on one port, W wins: a write is performed and no data is driven.
- **FSM states:** IDLE, WAIT, ACCESS, DONE.
  - IDLE: if any request is present, latch the winner's port, op, address and wdata.
    - Go to WAIT if WAIT_STATES>0, else go to ACCESS.
  - WAIT: a counter loads WAIT_STATES−1 on entry and decrements; leave for ACCESS when the count reaches 0.
  - ACCESS: exactly one cycle.
    - Write: the array is updated at the end of this cycle.
    - Read: the array word is registered into the port's rdata at the end of this cycle.
  - DONE: exactly one cycle.
    - The granted port's ready is high.
    - `d_drive` is high only for a data-port read.
    - Next state is IDLE unconditionally.
- **Arbitration**
  - Data port has priority.
  - Starvation guard: a `last_was_data` flag is set by each data grant and cleared by each instruction grant.
  - When both ports request in IDLE and `last_was_data`=1, the instruction port wins.
- **Latched operands:** latched address and wdata are used for the access. Changes on the request inputs after the grant are ignored.
- **rdata registers:** each port's rdata holds its value until that port's next read completes. Writes do not change rdata.
- **Addressing:** addresses are taken modulo 2^ADDR_W; 0x00 and 0xFF are ordinary locations. Array contents are not reset.
- **Reset**
  - Takes effect at the next rising edge: state returns to IDLE.
  - Outputs go to reset values: `i_rdata`=0, `d_rdata`=0, `i_ready`=0, `d_ready`=0, `d_drive`=0, `busy`=0.
  - Internal: `last_was_data`=0, wait counter=0.
  - A write interrupted before its ACCESS edge is discarded and the array is unchanged.

## Timing
- **Latency:** request first sampled in IDLE in cycle 0, then:
  - WAIT occupies cycles 1..WAIT_STATES.
  - ACCESS is cycle WAIT_STATES+1.
  - DONE is cycle WAIT_STATES+2, when ready pulses and read data is valid.
- **Throughput:** one access every WAIT_STATES+3 cycles.
- **Ready pulse:** ready is high for exactly one cycle and never on both ports in the same cycle.
- **Master handshake**
  - The master must drop its request at the edge ending the DONE cycle.
  - A request still high in the following IDLE cycle is treated as a new request.
- **Data-bus drive:** `d_drive` is high exactly in the DONE cycle of a data read, coincident with `d_ready`.
- **Losing port:** a losing request stays pending and is evaluated again in the next IDLE cycle.

## Test plan
- **Write then read (WAIT_STATES=1):** D write 0xBEEF to 0x10, then D read of 0x10.
  - `d_ready` pulses 3 cycles after the read is sampled, with `d_rdata`=0xBEEF.
  - `d_drive` is high only during that cycle.
  - `i_ready` stays 0.
- **Arbitration:** preload 0x00=0x1111 and 0x20=0x2222; assert I fetch 0x00 and D read 0x20 in the same cycle.
  - D completes first (`d_rdata`=0x2222), then I (`i_rdata`=0x1111).
  - Re-asserting the D read immediately still loses to the pending I.
- **W+OE both high:** D_MEM_W=1, D_MEM_OE=1, address 0x40, data 0xA5A5.
  - `d_drive` stays 0 and `d_rdata` is unchanged.
  - A later read of 0x40 returns 0xA5A5.
- **Reset mid-write:** preload 0x30=0x1234; pulse reset during WAIT of a write of 0xFFFF to 0x30.
  - All outputs are 0 at the next edge.
  - A subsequent read of 0x30 returns 0x1234.
- **Wrap boundaries:** write 0x0F0F to 0xFF and 0xF0F0 to 0x00; read both back.
  - Values are distinct and correct; no aliasing.
- **Zero wait states:** WAIT_STATES=0, back-to-back I fetches of 0x01..0x04.
  - `i_ready` pulses every 3 cycles with the correct words.
  - `busy` is low exactly in each IDLE cycle.
